if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, branch/flush redirect
// and the IF/ID pipeline register feeding decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_rom_ce;
  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  logic [31:0] w_br_tgt;
  logic [31:0] w_flush_tgt;
  logic [31:0] w_pc_next_seq;

  assign w_br_tgt      = {branch_target[31:2], 2'b00};
  assign w_flush_tgt   = {new_pc[31:2], 2'b00};
  assign w_pc_next_seq = r_pc + 32'd4;

  assign rom_ce   = r_rom_ce;
  assign rom_addr = r_pc;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;
  assign id_valid = r_id_valid;

  // Fetch FSM and PC sequencing; redirects are word aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_rom_ce      <= 1'b0;
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state  <= FETCH;
          r_rom_ce <= 1'b1;
          r_pc     <= RESET_PC;
        end
        FETCH: begin
          r_rom_ce <= 1'b1;
          if (flush) begin
            r_pc         <= w_flush_tgt;
            r_pend_valid <= 1'b0;
          end else if (branch_flag && !stall_if) begin
            r_pc         <= w_br_tgt;
            r_pend_valid <= 1'b0;
          end else if (branch_flag) begin
            r_pend_target <= w_br_tgt;
            r_pend_valid  <= 1'b1;
          end else if (r_pend_valid && !stall_if) begin
            r_pc         <= r_pend_target;
            r_pend_valid <= 1'b0;
          end else if (!stall_if) begin
            r_pc <= w_pc_next_seq;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rom_ce <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush and IF stalls insert a nop bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_id_pc    <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_valid <= 1'b0;
    end else if (flush) begin
      r_id_pc    <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_valid <= 1'b0;
    end else if (stall_id) begin
      r_id_pc    <= r_id_pc;
      r_id_inst  <= r_id_inst;
      r_id_valid <= r_id_valid;
    end else if (stall_if) begin
      r_id_pc    <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_valid <= 1'b0;
    end else begin
      r_id_pc    <= r_pc;
      r_id_inst  <= rom_inst;
      r_id_valid <= r_rom_ce;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequencing, stalls,
// delayed/flushed redirects, PC wrap and reset override.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        sif;
    logic        sid;
    logic        br;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] npc;
    logic        e_ce;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_val;
  } vec_t;

  vec_t vq[$];

  if_stage #(.RESET_PC(32'h00000000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .flush        (flush),
    .new_pc       (new_pc),
    .rom_ce       (rom_ce),
    .rom_addr     (rom_addr),
    .rom_inst     (rom_inst),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid)
  );

  assign rom_inst = rom_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic si, input logic sd,
    input logic b, input logic [31:0] t,
    input logic f, input logic [31:0] n,
    input logic ce, input logic [31:0] a,
    input logic [31:0] p, input logic [31:0] ins,
    input logic v);
    vec_t x;
    x.rst = r; x.sif = si; x.sid = sd;
    x.br = b; x.tgt = t; x.fl = f; x.npc = n;
    x.e_ce = ce; x.e_addr = a; x.e_pc = p;
    x.e_inst = ins; x.e_val = v;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    rst           = x.rst;
    stall_if      = x.sif;
    stall_id      = x.sid;
    branch_flag   = x.br;
    branch_target = x.tgt;
    flush         = x.fl;
    new_pc        = x.npc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t x);
    chk("rom_ce",   idx, {31'b0, rom_ce},   {31'b0, x.e_ce});
    chk("rom_addr", idx, rom_addr,          x.e_addr);
    chk("id_pc",    idx, id_pc,             x.e_pc);
    chk("id_inst",  idx, id_inst,           x.e_inst);
    chk("id_valid", idx, {31'b0, id_valid}, {31'b0, x.e_val});
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
    branch_flag = 1'b0; branch_target = Z;
    flush = 1'b0; new_pc = Z;

    // rst si sd br tgt fl npc | ce addr pc inst val
    vq.push_back(mk(0,0,0,0,Z,0,Z, 0,Z,Z,Z,0));
    vq.push_back(mk(0,1,1,1,32'h44,1,32'h88, 0,Z,Z,Z,0));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,Z,Z,Z,0));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h4,Z,Z,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h8,32'h4,32'h4,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'hC,32'h8,32'h8,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h10,32'hC,32'hC,1));
    vq.push_back(mk(1,1,0,0,Z,0,Z, 1,32'h10,Z,Z,0));
    vq.push_back(mk(1,1,0,0,Z,0,Z, 1,32'h10,Z,Z,0));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h14,32'h10,32'h10,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h18,32'h14,32'h14,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h1C,32'h18,32'h18,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h20,32'h1C,32'h1C,1));
    vq.push_back(mk(1,0,0,1,32'h100,0,Z, 1,32'h100,32'h20,32'h20,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h104,32'h100,32'h100,1));
    vq.push_back(mk(1,0,1,0,Z,0,Z, 1,32'h108,32'h100,32'h100,1));
    vq.push_back(mk(1,1,0,1,32'h203,0,Z, 1,32'h108,Z,Z,0));
    vq.push_back(mk(1,1,0,0,Z,0,Z, 1,32'h108,Z,Z,0));
    vq.push_back(mk(1,1,0,0,Z,0,Z, 1,32'h108,Z,Z,0));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h200,32'h108,32'h108,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h204,32'h200,32'h200,1));
    vq.push_back(mk(1,0,1,1,32'h40,1,32'h180, 1,32'h180,Z,Z,0));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h184,32'h180,32'h180,1));
    vq.push_back(mk(1,1,0,1,32'h300,0,Z, 1,32'h184,Z,Z,0));
    vq.push_back(mk(1,1,0,1,32'h402,0,Z, 1,32'h184,Z,Z,0));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h400,32'h184,32'h184,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h404,32'h400,32'h400,1));
    vq.push_back(mk(1,1,0,1,32'h500,0,Z, 1,32'h404,Z,Z,0));
    vq.push_back(mk(1,1,0,0,Z,1,32'h601, 1,32'h600,Z,Z,0));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h604,32'h600,32'h600,1));
    vq.push_back(mk(1,1,1,0,Z,0,Z, 1,32'h604,32'h600,32'h600,1));
    vq.push_back(mk(1,0,0,1,32'hFFFFFFFF,0,Z,
                    1,32'hFFFFFFFC,32'h604,32'h604,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z,
                    1,Z,32'hFFFFFFFC,32'hFFFFFFFC,1));
    vq.push_back(mk(1,0,0,0,Z,0,Z, 1,32'h4,Z,Z,1));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      chk_all(i, vq[i]);
    end

    // Reset in the middle of a stalled, pending redirect.
    drive(mk(1,1,0,1,32'h700,0,Z, 1,32'h4,Z,Z,0));
    chk("pend_setup_addr", 100, rom_addr, 32'h4);
    drive(mk(1,1,0,0,Z,0,Z, 1,32'h4,Z,Z,0));
    chk("pend_hold_addr", 101, rom_addr, 32'h4);
    drive(mk(0,1,0,1,32'h800,1,32'h900, 0,Z,Z,Z,0));
    chk("rst_ce", 102, {31'b0, rom_ce}, Z);
    chk("rst_addr", 102, rom_addr, Z);
    chk("rst_valid", 102, {31'b0, id_valid}, Z);
    drive(mk(1,0,0,0,Z,0,Z, 1,Z,Z,Z,0));
    chk("idle_exit_ce", 103, {31'b0, rom_ce}, 32'h1);
    chk("idle_exit_addr", 103, rom_addr, Z);
    drive(mk(1,0,0,0,Z,0,Z, 1,32'h4,Z,Z,1));
    chk("pend_lost_addr", 104, rom_addr, 32'h4);
    chk("pend_lost_valid", 104, {31'b0, id_valid}, 32'h1);
    drive(mk(1,0,0,0,Z,0,Z, 1,32'h8,32'h4,32'h4,1));
    chk("post_rst_addr", 105, rom_addr, 32'h8);
    chk("post_rst_inst", 105, id_inst, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
